vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Three-way arbiter for the single-port 8 KB video RAM, shared by the LCD scanout fetch, the CPU bus and the DMA engine. It sits between the LCD controller, the CPU decode logic, the DMA block and the VRAM macro. Each granted access runs through a fixed three-state pipeline, and the arbiter returns read data through per-requester data registers and one-cycle acknowledge pulses. The LCD normally wins. A starvation limit guarantees the CPU forward progress, and CPU/DMA contention is resolved round-robin.

## Interface
- CPU_STARVE_LIMIT, 4: number of consecutive arbitrations the CPU may lose to the LCD; at this count the CPU outranks the LCD (legal range 1–15).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ce  in  1  arbitration slot enable; a new access may start only on a clk where ce=1.
- lcd_req  in  1  LCD fetch request, read only; held until lcd_ack.
- lcd_addr  in  13  LCD byte address.
- lcd_rdata  out  8  registered read data for the LCD.
- lcd_ack  out  1  one-clk pulse; lcd_rdata is valid from this clk on.
- cpu_req / cpu_we  in  1/1  CPU request and write flag; held until cpu_ack.
- cpu_addr / cpu_wdata  in  13/8  CPU address and write data.
- cpu_rdata / cpu_ack  out  8/1  CPU read data and one-clk acknowledge.
- dma_req / dma_we  in  1/1  DMA request and write flag; held until dma_ack.
- dma_addr / dma_wdata  in  13/8  DMA address and write data.
- dma_rdata / dma_ack  out  8/1  DMA read data and one-clk acknowledge.
- ram_addr  out  13  registered VRAM address.
- ram_we  out  1  registered VRAM write enable.
- ram_wdata  out  8  registered VRAM write data.
- ram_rdata  in  8  VRAM read data; valid one clk after the address is presented.
- cpu_starved  out  1  high while the starvation count is at or above CPU_STARVE_LIMIT.

## Operation
- States are IDLE, ACCESS and DATA.
- IDLE → ACCESS happens only on a clk with ce=1 and at least one eligible request. Otherwise the arbiter stays in IDLE.
- ACCESS → DATA, then DATA → IDLE, each advance unconditionally on the next clk.
- A ce pulse that arrives in ACCESS or DATA is dropped. It is not queued.
- A requester whose ack is high on the current clk is ineligible on that clk. This prevents a stale req from being granted twice.
- Grant priority, evaluated in IDLE with ce=1:
  1. If the CPU is starved (count ≥ CPU_STARVE_LIMIT) and cpu_req is high, the CPU wins.
  2. Otherwise lcd_req wins.
  3. Otherwise, between CPU and DMA, the round-robin pointer decides: the requester that did not win the last CPU/DMA grant wins. A lone requester wins regardless of the pointer.
- The round-robin pointer updates only on CPU or DMA grants. After reset it favours the CPU.
- Starvation count (4-bit, saturating):
  - Increments when cpu_req is high and the LCD is granted.
  - Clears to 0 on any CPU grant.
  - Is unchanged otherwise, including when the DMA wins.
- On grant, the winner's addr, we and wdata are registered into ram_addr, ram_we and ram_wdata, so the RAM sees them during ACCESS. LCD grants always have we=0.
- ram_we is 1 only during the ACCESS clk of a write and 0 in every other state.
- ram_addr and ram_wdata hold their last value outside ACCESS.
- In DATA, ram_rdata is captured into the winner's rdata register and the winner's ack is set. Both are visible on the clk after DATA.
- Writes also ack, but they leave that requester's rdata unchanged.
- Ordering: accesses complete strictly in grant order. An LCD read of an address that the CPU wrote in an earlier grant returns the new data.
- Addresses pass through unmodified as 13 bits; there is no wrap or offset logic in this block.

## Timing
- Latency: a request granted on clk T produces its ack on T+3. The next grant can occur on T+3 at the earliest, if ce=1 then.
- Peak throughput is one access per 3 clks.
- Reset values:
  - state=IDLE.
  - All acks 0.
  - All rdata registers 8'h00.
  - ram_addr=0, ram_we=0, ram_wdata=0.
  - Starvation count 0, cpu_starved=0.
  - Round-robin pointer favours the CPU.
- Reset asserted in ACCESS or DATA aborts the access. ram_we is 0 from the next clk, and no ack is issued for the aborted access.
- A write registered on the clk reset asserts is never presented to the RAM.
- Requests arriving while the arbiter is busy wait without loss; the requester holds req until it sees its ack.

## Test plan
- CPU read only, address 0x0123 holding 0xA5, ce=1 every clk → ram_addr=0x0123 at T+1; cpu_ack pulses at T+3 with cpu_rdata=0xA5; no second grant on T+3.
- LCD and CPU requesting continuously, CPU_STARVE_LIMIT=4, ce every clk → grant sequence LCD,LCD,LCD,LCD,CPU repeating; cpu_starved high during the slot before each CPU grant.
- CPU and DMA requesting continuously, no LCD → grants alternate CPU,DMA,CPU,DMA starting with the CPU after reset.
- CPU writes 0x5A to 0x1FFF, then the LCD reads 0x1FFF → ram_we high for exactly one clk; lcd_rdata=0x5A; cpu_rdata unchanged.
- Reset asserted in ACCESS during a DMA write → ram_we=0 on the next clk; no dma_ack; all outputs at reset values.
- ce pulsed only every 4 clks with all three requesters active → each access starts exactly on a ce clk, the LCD first, and no ack is ever duplicated.

Source files
------------

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// vram_arbiter : LCD / CPU / DMA arbiter for the single-port 8 KB video RAM
// Revision     : 1.0
// ============================================================================
module vram_arbiter #(
  parameter int CPU_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ce,
  input  logic        i_lcd_req,
  input  logic [12:0] i_lcd_addr,
  output logic [7:0]  o_lcd_rdata,
  output logic        o_lcd_ack,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [12:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_ack,
  input  logic        i_dma_req,
  input  logic        i_dma_we,
  input  logic [12:0] i_dma_addr,
  input  logic [7:0]  i_dma_wdata,
  output logic [7:0]  o_dma_rdata,
  output logic        o_dma_ack,
  output logic [12:0] o_ram_addr,
  output logic        o_ram_we,
  output logic [7:0]  o_ram_wdata,
  input  logic [7:0]  i_ram_rdata,
  output logic        o_cpu_starved
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DATA = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_LCD = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} owner_t;

  localparam logic [3:0] c_STARVE_LIMIT = 4'(CPU_STARVE_LIMIT);

  state_t      r_state;
  owner_t      r_owner;
  logic        r_is_write;
  logic [3:0]  r_starve;
  logic        r_rr_cpu;
  logic        r_lcd_ack, r_cpu_ack, r_dma_ack;
  logic [7:0]  r_lcd_rdata, r_cpu_rdata, r_dma_rdata;
  logic [12:0] r_ram_addr;
  logic        r_ram_we;
  logic [7:0]  r_ram_wdata;

  logic        w_lcd_elig, w_cpu_elig, w_dma_elig, w_starved;
  logic        w_grant;
  owner_t      w_winner;
  logic [12:0] w_addr;
  logic        w_we;
  logic [7:0]  w_wdata;

  // A requester still showing its ack is holding a stale request.
  assign w_lcd_elig = i_lcd_req & ~r_lcd_ack;
  assign w_cpu_elig = i_cpu_req & ~r_cpu_ack;
  assign w_dma_elig = i_dma_req & ~r_dma_ack;
  assign w_starved  = (r_starve >= c_STARVE_LIMIT);

  always_comb begin
    w_grant  = 1'b0;
    w_winner = OWN_LCD;
    if (r_state == S_IDLE && i_ce) begin
      if (w_starved && w_cpu_elig) begin
        w_grant  = 1'b1;
        w_winner = OWN_CPU;
      end else if (w_lcd_elig) begin
        w_grant  = 1'b1;
        w_winner = OWN_LCD;
      end else if (w_cpu_elig && (r_rr_cpu || !w_dma_elig)) begin
        w_grant  = 1'b1;
        w_winner = OWN_CPU;
      end else if (w_dma_elig) begin
        w_grant  = 1'b1;
        w_winner = OWN_DMA;
      end
    end
  end

  always_comb begin
    w_addr  = i_lcd_addr;
    w_we    = 1'b0;
    w_wdata = 8'h00;
    case (w_winner)
      OWN_CPU: begin
        w_addr  = i_cpu_addr;
        w_we    = i_cpu_we;
        w_wdata = i_cpu_wdata;
      end
      OWN_DMA: begin
        w_addr  = i_dma_addr;
        w_we    = i_dma_we;
        w_wdata = i_dma_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_LCD;
      r_is_write  <= 1'b0;
      r_starve    <= 4'd0;
      r_rr_cpu    <= 1'b1;
      r_lcd_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_lcd_rdata <= 8'h00;
      r_cpu_rdata <= 8'h00;
      r_dma_rdata <= 8'h00;
      r_ram_addr  <= 13'd0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= 8'h00;
    end else begin
      r_lcd_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state     <= S_ACCESS;
            r_owner     <= w_winner;
            r_is_write  <= w_we;
            r_ram_addr  <= w_addr;
            r_ram_we    <= w_we;
            r_ram_wdata <= w_wdata;
            if (w_winner == OWN_CPU) begin
              r_starve <= 4'd0;
              r_rr_cpu <= 1'b0;
            end else if (w_winner == OWN_DMA) begin
              r_rr_cpu <= 1'b1;
            end else if (i_cpu_req && r_starve != 4'hF) begin
              r_starve <= r_starve + 4'd1;
            end
          end
        end
        S_ACCESS: begin
          r_state  <= S_DATA;
          r_ram_we <= 1'b0;
        end
        S_DATA: begin
          r_state <= S_IDLE;
          case (r_owner)
            OWN_CPU: begin
              r_cpu_ack <= 1'b1;
              if (!r_is_write) r_cpu_rdata <= i_ram_rdata;
            end
            OWN_DMA: begin
              r_dma_ack <= 1'b1;
              if (!r_is_write) r_dma_rdata <= i_ram_rdata;
            end
            default: begin
              r_lcd_ack   <= 1'b1;
              r_lcd_rdata <= i_ram_rdata;
            end
          endcase
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_lcd_rdata   = r_lcd_rdata;
  assign o_lcd_ack     = r_lcd_ack;
  assign o_cpu_rdata   = r_cpu_rdata;
  assign o_cpu_ack     = r_cpu_ack;
  assign o_dma_rdata   = r_dma_rdata;
  assign o_dma_ack     = r_dma_ack;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_we      = r_ram_we;
  assign o_ram_wdata   = r_ram_wdata;
  assign o_cpu_starved = w_starved;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vram_arbiter : directed and randomized checks of vram_arbiter
// Revision        : 1.0
// ============================================================================
module tb_vram_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset, ce;
  logic        lcd_req, cpu_req, cpu_we, dma_req, dma_we;
  logic [12:0] lcd_addr, cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic [7:0]  lcd_rdata, cpu_rdata, dma_rdata;
  logic        lcd_ack, cpu_ack, dma_ack;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        cpu_starved;

  always #5 clk = ~clk;

  vram_arbiter #(.CPU_STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .i_ce(ce),
    .i_lcd_req(lcd_req), .i_lcd_addr(lcd_addr), .o_lcd_rdata(lcd_rdata), .o_lcd_ack(lcd_ack),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_rdata(dma_rdata), .o_dma_ack(dma_ack),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_cpu_starved(cpu_starved)
  );

  // VRAM macro: synchronous read, with a backdoor used only while the arbiter is idle
  logic [7:0]  ram [0:8191];
  logic        bd_fill, bd_we;
  logic [12:0] bd_addr;
  logic [7:0]  bd_data;
  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < 8192; i++) ram[i] <= 8'(i * 37 + 11);
    end else begin
      if (bd_we) ram[bd_addr] <= bd_data;
      if (ram_we) ram[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr];
  end

  int checks = 0;
  int failures = 0;

  // Reference model: tracks the last grant as an edge number, not as a state machine
  int          cyc;
  int          m_g, m_who, m_starve;
  bit          m_we, m_rr_cpu;
  logic [7:0]  m_data;
  logic [7:0]  m_mem [0:8191];
  bit          e_ack [3];
  logic [7:0]  e_rd [3];
  bit          e_we, e_starved;
  logic [12:0] e_addr;
  logic [7:0]  e_wdata;

  task automatic model_edge();
    int e;
    int win;
    bit rq[3];
    bit wq[3];
    bit el[3];
    logic [12:0] aq[3];
    logic [7:0] dq[3];
    e  = cyc + 1;
    rq = '{lcd_req, cpu_req, dma_req};
    wq = '{1'b0, cpu_we, dma_we};
    aq = '{lcd_addr, cpu_addr, dma_addr};
    dq = '{8'h00, cpu_wdata, dma_wdata};
    win = -1;
    for (int x = 0; x < 3; x++) e_ack[x] = 1'b0;
    e_we = 1'b0;
    if (reset) begin
      m_g = -100; m_starve = 0; m_rr_cpu = 1'b1; m_we = 1'b0;
      e_addr = 13'd0; e_wdata = 8'h00;
      for (int x = 0; x < 3; x++) e_rd[x] = 8'h00;
    end else begin
      for (int x = 0; x < 3; x++) el[x] = rq[x] && !(m_g == e - 3 && m_who == x);
      if (e >= m_g + 3 && ce) begin
        if (m_starve >= LIMIT && el[1]) win = 1;
        else if (el[0]) win = 0;
        else if (el[1] && el[2]) win = m_rr_cpu ? 1 : 2;
        else if (el[1]) win = 1;
        else if (el[2]) win = 2;
      end
      if (win == 0 && rq[1] && m_starve < 15) m_starve++;
      if (win == 1) begin m_starve = 0; m_rr_cpu = 1'b0; end
      if (win == 2) m_rr_cpu = 1'b1;
      if (win >= 0) begin
        m_g = e; m_who = win; m_we = wq[win];
        e_addr = aq[win]; e_we = m_we;
        if (m_we) begin
          m_mem[e_addr] = dq[win];
          e_wdata = dq[win];
        end else begin
          m_data = m_mem[e_addr];
        end
      end
      if (m_g == e - 2) begin
        e_ack[m_who] = 1'b1;
        if (!m_we) e_rd[m_who] = m_data;
      end
    end
    e_starved = (m_starve >= LIMIT);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    ce = 1'b0; lcd_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    cpu_we = 1'b0; dma_we = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [12:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    m_mem[a] = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({lcd_ack, cpu_ack, dma_ack, ram_we, cpu_starved} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {lcd_ack, cpu_ack, dma_ack, ram_we, cpu_starved});
    end
    checks++;
    if ({lcd_rdata, cpu_rdata, dma_rdata} !== 24'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=000000", {lcd_rdata, cpu_rdata, dma_rdata});
    end
    checks++;
    if (ram_addr !== 13'd0 || ram_wdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_ram got addr=%h wdata=%h exp 0000/00", ram_addr, ram_wdata);
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    preload(13'h0123, 8'hA5);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123; ce = 1'b1;
    tick();
    checks++;
    if (ram_addr !== 13'h0123 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_addr got addr=%h we=%b exp 0123/0", ram_addr, ram_we);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b0) begin failures++; $display("FAIL cpu_read_early_ack got=%b exp=0", cpu_ack); end
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
      failures++;
      $display("FAIL cpu_read_ack got ack=%b data=%h exp 1/a5", cpu_ack, cpu_rdata);
    end
    tick();
    cpu_req = 1'b0;
    checks++;
    if (cpu_ack !== 1'b0) begin failures++; $display("FAIL cpu_read_pulse got=%b exp=0", cpu_ack); end
    tick();
    tick();
    checks++;
    if (cpu_ack !== 1'b0) begin failures++; $display("FAIL cpu_read_regrant got=%b exp=0", cpu_ack); end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    int seq[$];
    int exp_seq[4] = '{1, 2, 1, 2};
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0200;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h0300; ce = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (cpu_ack) seq.push_back(1);
      if (dma_ack) seq.push_back(2);
    end
    checks++;
    if (seq.size() != 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", seq.size()); end
    for (int i = 0; i < 4 && i < seq.size(); i++) begin
      checks++;
      if (seq[i] != exp_seq[i]) begin
        failures++;
        $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_ce_every4();
    int seq[$];
    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit bad_slot = 1'b0;
    do_reset();
    lcd_req = 1'b1; lcd_addr = 13'h0040;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0041;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h0042;
    for (int k = 0; k < 40; k++) begin
      ce = (k % 4 == 0);
      tick();
      if (lcd_ack) seq.push_back(0);
      if (cpu_ack) seq.push_back(1);
      if (dma_ack) seq.push_back(2);
      if ((lcd_ack || cpu_ack || dma_ack) && (k % 4 != 2)) bad_slot = 1'b1;
      if (int'(lcd_ack) + int'(cpu_ack) + int'(dma_ack) > 1) bad_slot = 1'b1;
      if (k == 15) begin
        checks++;
        if (cpu_starved !== 1'b1) begin failures++; $display("FAIL starved_before_grant got=%b exp=1", cpu_starved); end
      end
      if (k == 16) begin
        checks++;
        if (cpu_starved !== 1'b0) begin failures++; $display("FAIL starved_after_grant got=%b exp=0", cpu_starved); end
      end
    end
    checks++;
    if (seq.size() != 10) begin failures++; $display("FAIL ce4_count got=%0d exp=10", seq.size()); end
    for (int i = 0; i < 10 && i < seq.size(); i++) begin
      checks++;
      if (seq[i] != exp_seq[i]) begin
        failures++;
        $display("FAIL ce4_order idx=%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]);
      end
    end
    checks++;
    if (bad_slot) begin failures++; $display("FAIL ce4_ack_slot got=misplaced exp=one ack 2 clks after each ce"); end
    idle_inputs();
  endtask

  task automatic test_write_then_lcd();
    int  we_cnt = 0;
    bit  got = 1'b0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'h5A; ce = 1'b1;
    for (int k = 0; k < 12 && !got; k++) begin
      tick();
      if (ram_we) begin
        we_cnt++;
        checks++;
        if (ram_addr !== 13'h1FFF || ram_wdata !== 8'h5A) begin
          failures++;
          $display("FAIL wr_bus got addr=%h data=%h exp 1fff/5a", ram_addr, ram_wdata);
        end
      end
      if (cpu_ack) begin cpu_req = 1'b0; cpu_we = 1'b0; lcd_req = 1'b1; lcd_addr = 13'h1FFF; end
      if (lcd_ack) begin got = 1'b1; lcd_req = 1'b0; end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL wr_lcd_ack got=timeout exp=ack"); end
    checks++;
    if (we_cnt != 1) begin failures++; $display("FAIL wr_we_cycles got=%0d exp=1", we_cnt); end
    checks++;
    if (lcd_rdata !== 8'h5A) begin failures++; $display("FAIL wr_lcd_data got=%h exp=5a", lcd_rdata); end
    checks++;
    if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL wr_cpu_rdata got=%h exp=00", cpu_rdata); end
    idle_inputs();
  endtask

  task automatic test_reset_abort();
    bit saw_ack = 1'b0;
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 13'h0AAA; dma_wdata = 8'h3C; ce = 1'b1;
    tick();
    checks++;
    if (ram_we !== 1'b1) begin failures++; $display("FAIL abort_grant got we=%b exp=1", ram_we); end
    reset = 1'b1;
    tick();
    checks++;
    if ({lcd_ack, cpu_ack, dma_ack, ram_we, cpu_starved} !== 5'b0 || ram_addr !== 13'd0 ||
        ram_wdata !== 8'h00 || {lcd_rdata, cpu_rdata, dma_rdata} !== 24'h0) begin
      failures++;
      $display("FAIL abort_outputs got ctrl=%b addr=%h wdata=%h exp all zero",
               {lcd_ack, cpu_ack, dma_ack, ram_we, cpu_starved}, ram_addr, ram_wdata);
    end
    reset = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (dma_ack) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack) begin failures++; $display("FAIL abort_ack got=1 exp=0"); end
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0555; cpu_wdata = 8'hFF; ce = 1'b1;
    tick();
    checks++;
    if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_on_grant got we=%b exp=0", ram_we); end
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    checks++;
    if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_on_grant_late got we=%b exp=0", ram_we); end
    idle_inputs();
  endtask

  function automatic logic [12:0] raddr();
    if ($urandom_range(0, 3) == 0) return 13'($urandom);
    return 13'h1FF0 | 13'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      ce    = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if ({lcd_ack, cpu_ack, dma_ack, ram_we, cpu_starved} !==
          {e_ack[0], e_ack[1], e_ack[2], e_we, e_starved}) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", cyc, {lcd_ack, cpu_ack, dma_ack, ram_we, cpu_starved},
                 {e_ack[0], e_ack[1], e_ack[2], e_we, e_starved});
      end
      checks++;
      if ({lcd_rdata, cpu_rdata, dma_rdata} !== {e_rd[0], e_rd[1], e_rd[2]}) begin
        failures++;
        $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, {lcd_rdata, cpu_rdata, dma_rdata},
                 {e_rd[0], e_rd[1], e_rd[2]});
      end
      checks++;
      if (ram_addr !== e_addr) begin
        failures++;
        $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, ram_addr, e_addr);
      end
      if (e_we) begin
        checks++;
        if (ram_wdata !== e_wdata) begin
          failures++;
          $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, ram_wdata, e_wdata);
        end
      end
      // Requesters hold until acked, then pick a fresh transaction or go quiet
      if (e_ack[0] || !lcd_req) begin
        lcd_req = $urandom_range(0, 1); lcd_addr = raddr();
      end
      if (e_ack[1] || !cpu_req) begin
        cpu_req = $urandom_range(0, 1); cpu_we = $urandom_range(0, 1);
        cpu_addr = raddr(); cpu_wdata = 8'($urandom);
      end
      if (e_ack[2] || !dma_req) begin
        dma_req = $urandom_range(0, 1); dma_we = $urandom_range(0, 1);
        dma_addr = raddr(); dma_wdata = 8'($urandom);
      end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    cyc = 0;
    m_g = -100; m_who = 0; m_starve = 0; m_we = 1'b0; m_rr_cpu = 1'b1; m_data = 8'h00;
    for (int i = 0; i < 8192; i++) m_mem[i] = 8'(i * 37 + 11);
    lcd_addr = 13'd0; cpu_addr = 13'd0; dma_addr = 13'd0;
    cpu_wdata = 8'h00; dma_wdata = 8'h00;
    bd_we = 1'b0; bd_addr = 13'd0; bd_data = 8'h00;
    bd_fill = 1'b1;
    idle_inputs();
    reset = 1'b1;
    tick();
    bd_fill = 1'b0;

    test_reset();
    test_cpu_read();
    test_round_robin();
    test_ce_every4();
    test_write_then_lcd();
    test_reset_abort();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
